loop_nest_controller: RTL

Sequencer for `mem_walker_stride`.
- Holds up to `NUM_MAX_LOOPS` nested loop iteration counts, written by the instruction decoder.
- On `start`, walks the loop nest and emits the walker's control pulses: `loop_init`, `loop_enter`, `loop_index_valid`, `loop_exit` with `loop_index`, then `loop_ctrl_done`.
- Sits between the instruction decoder and the walker; one controller drives one walker.

---
 rtl/loop_ctrl_pkg.sv | 17 +
 rtl/loop_nest_controller_if.sv | 31 +++
 rtl/loop_cfg_regfile.sv | 42 ++++
 rtl/loop_nest_controller.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/loop_ctrl_pkg.sv
// rtl/loop_ctrl_pkg.sv - shared state encoding and default widths for the loop controller and walker
package loop_ctrl_pkg;

  localparam int LOOP_ID_W_DEF     = 5;
  localparam int LOOP_ITER_W_DEF   = 16;
  localparam int NUM_MAX_LOOPS_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INIT    = 3'd1,
    ST_INNER   = 3'd2,
    ST_ADVANCE = 3'd3,
    ST_EXIT    = 3'd4,
    ST_DONE    = 3'd5
  } loop_state_e;

endpackage

// File: rtl/loop_nest_controller_if.sv
// rtl/loop_nest_controller_if.sv - decoder/walker-facing signals of the loop nest controller
interface loop_nest_controller_if
  import loop_ctrl_pkg::*;
#(
  parameter int LOOP_ID_W   = LOOP_ID_W_DEF,
  parameter int LOOP_ITER_W = LOOP_ITER_W_DEF
);

  logic                   cfg_loop_iter_v;
  logic [LOOP_ITER_W-1:0] cfg_loop_iter;
  logic                   start;
  logic                   stall;
  logic                   busy;
  logic                   loop_init;
  logic                   loop_enter;
  logic                   loop_index_valid;
  logic                   loop_exit;
  logic [LOOP_ID_W-1:0]   loop_index;
  logic                   loop_ctrl_done;

  modport master (
    output cfg_loop_iter_v, cfg_loop_iter, start, stall,
    input  busy, loop_init, loop_enter, loop_index_valid, loop_exit, loop_index, loop_ctrl_done
  );

  modport slave (
    input  cfg_loop_iter_v, cfg_loop_iter, start, stall,
    output busy, loop_init, loop_enter, loop_index_valid, loop_exit, loop_index, loop_ctrl_done
  );

endinterface

// File: rtl/loop_cfg_regfile.sv
// rtl/loop_cfg_regfile.sv - per-level iteration-count storage, one sync write port, two async read ports
module loop_cfg_regfile
  import loop_ctrl_pkg::*;
#(
  parameter int NUM_MAX_LOOPS = NUM_MAX_LOOPS_DEF,
  parameter int LOOP_ID_W     = LOOP_ID_W_DEF,
  parameter int LOOP_ITER_W   = LOOP_ITER_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [LOOP_ID_W-1:0]   wr_addr,
  input  logic [LOOP_ITER_W-1:0] wr_data,
  input  logic [LOOP_ID_W-1:0]   rd_addr_a,
  output logic [LOOP_ITER_W-1:0] rd_data_a,
  input  logic [LOOP_ID_W-1:0]   rd_addr_b,
  output logic [LOOP_ITER_W-1:0] rd_data_b
);

  logic [LOOP_ITER_W-1:0] mem [NUM_MAX_LOOPS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_MAX_LOOPS; i++) mem[i] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NUM_MAX_LOOPS; i++) begin
        if (wr_addr == LOOP_ID_W'(i)) mem[i] <= wr_data;
      end
    end
  end

  // Out-of-range addresses (e.g. level-1 while at level 0) read as zero.
  always_comb begin
    rd_data_a = '0;
    rd_data_b = '0;
    for (int i = 0; i < NUM_MAX_LOOPS; i++) begin
      if (rd_addr_a == LOOP_ID_W'(i)) rd_data_a = mem[i];
      if (rd_addr_b == LOOP_ID_W'(i)) rd_data_b = mem[i];
    end
  end

endmodule

// File: rtl/loop_nest_controller.sv
// rtl/loop_nest_controller.sv - walks a configured loop nest and emits walker control pulses
module loop_nest_controller
  import loop_ctrl_pkg::*;
#(
  parameter int NUM_MAX_LOOPS = NUM_MAX_LOOPS_DEF,
  parameter int LOOP_ID_W     = LOOP_ID_W_DEF,
  parameter int LOOP_ITER_W   = LOOP_ITER_W_DEF
) (
  input logic                   clk,
  input logic                   reset,
  loop_nest_controller_if.slave bus
);

  localparam int NUM_W = $clog2(NUM_MAX_LOOPS + 1);

  loop_state_e            state, state_nxt;
  logic [LOOP_ID_W-1:0]   level, level_nxt, level_m1, last_level;
  logic [NUM_W-1:0]       num_loops;
  logic [LOOP_ITER_W-1:0] cnt [NUM_MAX_LOOPS];
  logic [LOOP_ITER_W-1:0] iter_cur, iter_prev, cnt_cur, cnt_prev;
  logic                   cfg_we, cnt_inc, cnt_clr, clr_all;
  logic                   p_init, p_enter, p_valid, p_exit, p_done;
  logic [LOOP_ID_W-1:0]   p_index;

  assign level_m1   = level - 1'b1;
  assign last_level = LOOP_ID_W'(num_loops - 1'b1);
  assign cfg_we     = (state == ST_IDLE) && !bus.stall && bus.cfg_loop_iter_v &&
                      (num_loops < NUM_W'(NUM_MAX_LOOPS));

  loop_cfg_regfile #(
    .NUM_MAX_LOOPS (NUM_MAX_LOOPS),
    .LOOP_ID_W     (LOOP_ID_W),
    .LOOP_ITER_W   (LOOP_ITER_W)
  ) u_regfile (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (cfg_we),
    .wr_addr   (LOOP_ID_W'(num_loops)),
    .wr_data   (bus.cfg_loop_iter),
    .rd_addr_a (level),
    .rd_data_a (iter_cur),
    .rd_addr_b (level_m1),
    .rd_data_b (iter_prev)
  );

  always_comb begin
    cnt_cur  = '0;
    cnt_prev = '0;
    for (int i = 0; i < NUM_MAX_LOOPS; i++) begin
      if (level == LOOP_ID_W'(i))    cnt_cur  = cnt[i];
      if (level_m1 == LOOP_ID_W'(i)) cnt_prev = cnt[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    level_nxt = level;
    cnt_inc   = 1'b0;
    cnt_clr   = 1'b0;
    clr_all   = 1'b0;
    p_init    = 1'b0;
    p_enter   = 1'b0;
    p_valid   = 1'b0;
    p_exit    = 1'b0;
    p_done    = 1'b0;
    p_index   = '0;
    unique case (state)
      ST_IDLE: begin
        if (bus.start) state_nxt = (num_loops != '0) ? ST_INIT : ST_DONE;
      end
      ST_INIT: begin
        p_init    = 1'b1;
        level_nxt = last_level;
        state_nxt = ST_INNER;
      end
      ST_INNER: begin
        p_valid = 1'b1;
        p_index = level;
        if (cnt_cur == iter_cur) state_nxt = ST_EXIT;
        else                     cnt_inc   = 1'b1;
      end
      ST_EXIT: begin
        p_exit  = 1'b1;
        p_index = level;
        cnt_clr = 1'b1;
        if (level == '0) begin
          state_nxt = ST_DONE;
        end else begin
          level_nxt = level_m1;
          state_nxt = (cnt_prev == iter_prev) ? ST_EXIT : ST_ADVANCE;
        end
      end
      ST_ADVANCE: begin
        p_enter   = 1'b1;
        p_index   = level;
        cnt_inc   = 1'b1;
        level_nxt = last_level;
        state_nxt = ST_INNER;
      end
      ST_DONE: begin
        p_done    = 1'b1;
        clr_all   = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    // Stall holds every register and silences the pulses for this cycle.
    if (bus.stall) begin
      state_nxt = state;
      level_nxt = level;
      cnt_inc   = 1'b0;
      cnt_clr   = 1'b0;
      clr_all   = 1'b0;
      p_init    = 1'b0;
      p_enter   = 1'b0;
      p_valid   = 1'b0;
      p_exit    = 1'b0;
      p_done    = 1'b0;
      p_index   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      level     <= '0;
      num_loops <= '0;
      for (int i = 0; i < NUM_MAX_LOOPS; i++) cnt[i] <= '0;
    end else begin
      level <= level_nxt;
      if (clr_all) begin
        num_loops <= '0;
        for (int i = 0; i < NUM_MAX_LOOPS; i++) cnt[i] <= '0;
      end else begin
        if (cfg_we) num_loops <= num_loops + 1'b1;
        for (int i = 0; i < NUM_MAX_LOOPS; i++) begin
          if (level == LOOP_ID_W'(i)) begin
            if (cnt_inc)      cnt[i] <= cnt[i] + 1'b1;
            else if (cnt_clr) cnt[i] <= '0;
          end
        end
      end
    end
  end

  assign bus.busy             = (state != ST_IDLE);
  assign bus.loop_init        = p_init;
  assign bus.loop_enter       = p_enter;
  assign bus.loop_index_valid = p_valid;
  assign bus.loop_exit        = p_exit;
  assign bus.loop_index       = p_index;
  assign bus.loop_ctrl_done   = p_done;

endmodule
